hazard_pipe_ctrl: RTL and testbench

- Consumer side of the hazard-control interface: owns PC register, IF/ID register and ID/EX control/operand-index register.
- Applies StallF/StallD/FlushD/FlushE/PCSrcE exactly as the hazard unit produces them.
- Sits between fetch, decode and execute in the 5-stage RV32I pipeline.
- Also keeps saturating event counters (stall cycles, redirects, bubbles) for performance debug.

---
 rtl/hazard_pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline register control for the F/D/E stages of a 5-stage RV32I core.
// Applies the hazard unit's stall/flush/redirect controls and keeps saturating event counters.
module hazard_pipe_ctrl #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic [31:0]      InstrF,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic [XLEN-1:0]  PCF,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             BranchE,
    output logic             JumpE,
    output logic [1:0]       ResultSrcE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [XLEN-1:0]  PCE,
    output logic             ValidE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] RedirCnt,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            valid;
    } idex_t;

    localparam ifid_t IFID_EMPTY = '{instr: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [XLEN-1:0]  pcf_q, pcf_d;
    ifid_t            ifid_q, ifid_d;
    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && (cnt != '1)) ? cnt + CNT_ONE : cnt;
    endfunction

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        pcf_d  = pcf_q;
        ifid_d = ifid_q;
        idex_d = idex_q;

        if (PCSrcE)       pcf_d = PCTargetE;
        else if (!StallF) pcf_d = pcf_q + PC_STEP;

        if (FlushD) begin
            ifid_d = IFID_EMPTY;
        end else if (!StallD) begin
            ifid_d = '{instr: InstrF, pc: pcf_q, pc_plus4: pcf_q + PC_STEP, valid: 1'b1};
        end

        // An all-zero bubble has RegWrite=0 and ResultSrc=0, so it never forwards or stalls.
        if (FlushE) begin
            idex_d = '0;
        end else begin
            idex_d = '{reg_write: RegWriteD, mem_write: MemWriteD, branch: BranchD,
                       jump: JumpD, result_src: ResultSrcD, rs1: Rs1D, rs2: Rs2D,
                       rd: RdD, pc: ifid_q.pc, valid: ifid_q.valid};
        end

        stall_cnt_d  = sat_inc(stall_cnt_q,  StallD);
        redir_cnt_d  = sat_inc(redir_cnt_q,  PCSrcE);
        bubble_cnt_d = sat_inc(bubble_cnt_q, FlushE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q        <= RESET_PC;
            ifid_q       <= IFID_EMPTY;
            idex_q       <= '0;
            stall_cnt_q  <= '0;
            redir_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pcf_q        <= pcf_d;
            ifid_q       <= ifid_d;
            idex_q       <= idex_d;
            stall_cnt_q  <= stall_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign PCF        = pcf_q;
    assign InstrD     = ifid_q.instr;
    assign PCD        = ifid_q.pc;
    assign PCPlus4D   = ifid_q.pc_plus4;
    assign ValidD     = ifid_q.valid;
    assign RegWriteE  = idex_q.reg_write;
    assign MemWriteE  = idex_q.mem_write;
    assign BranchE    = idex_q.branch;
    assign JumpE      = idex_q.jump;
    assign ResultSrcE = idex_q.result_src;
    assign Rs1E       = idex_q.rs1;
    assign Rs2E       = idex_q.rs2;
    assign RdE        = idex_q.rd;
    assign PCE        = idex_q.pc;
    assign ValidE     = idex_q.valid;
    assign StallCnt   = stall_cnt_q;
    assign RedirCnt   = redir_cnt_q;
    assign BubbleCnt  = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed table-driven bench for hazard_pipe_ctrl, plus hand sequences for
// reset-during-stall and counter saturation on a narrow-counter instance.
module tb_hazard_pipe_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h0050_0093;
    localparam logic [31:0] I2  = 32'h00A0_0113;
    localparam logic [31:0] I3  = 32'h00F0_0193;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    // Decoded D-side inputs held constant: RegWrite, MemWrite, Branch, Jump, ResultSrc / Rs1, Rs2, Rd.
    localparam logic [5:0]  CTL_LIVE = 6'b111001;
    localparam logic [14:0] IDX_LIVE = {5'd1, 5'd2, 5'd5};

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [31:0] PCTargetE, InstrF;
    logic        RegWriteD = 1'b1, MemWriteD = 1'b1, BranchD = 1'b1, JumpD = 1'b0;
    logic [1:0]  ResultSrcD = 2'b01;
    logic [4:0]  Rs1D = 5'd1, Rs2D = 5'd2, RdD = 5'd5;

    logic [31:0] PCF, InstrD, PCD, PCPlus4D, PCE;
    logic        ValidD, RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [31:0] StallCnt, RedirCnt, BubbleCnt;

    logic [31:0] s_PCF, s_InstrD, s_PCD, s_PCPlus4D, s_PCE;
    logic        s_ValidD, s_RegWriteE, s_MemWriteE, s_BranchE, s_JumpE, s_ValidE;
    logic [1:0]  s_ResultSrcE;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]  s_StallCnt, s_RedirCnt, s_BubbleCnt;

    always #5 clk = ~clk;

    hazard_pipe_ctrl dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .JumpD(JumpD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
        .ValidE(ValidE), .StallCnt(StallCnt), .RedirCnt(RedirCnt), .BubbleCnt(BubbleCnt)
    );

    hazard_pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .JumpD(JumpD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .PCF(s_PCF), .InstrD(s_InstrD), .PCD(s_PCD), .PCPlus4D(s_PCPlus4D), .ValidD(s_ValidD),
        .RegWriteE(s_RegWriteE), .MemWriteE(s_MemWriteE), .BranchE(s_BranchE), .JumpE(s_JumpE),
        .ResultSrcE(s_ResultSrcE), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .PCE(s_PCE),
        .ValidE(s_ValidE), .StallCnt(s_StallCnt), .RedirCnt(s_RedirCnt), .BubbleCnt(s_BubbleCnt)
    );

    typedef struct {
        logic        rst, sf, sd, fd, fe, ps;
        logic [31:0] tgt, instr;
        logic [31:0] pcf, instr_d, pcd, pc4d;
        logic        vd, live;
        logic [31:0] pce;
        logic        ve;
        logic [31:0] sc, rc, bc;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, sf, sd, fd, fe, ps, input logic [31:0] tgt, instr,
        input logic [31:0] pcf, instr_d, pcd, pc4d, input logic vd, live,
        input logic [31:0] pce, input logic ve, input logic [31:0] sc, rc, bc);
        vec_t v;
        v.rst = rst_i; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe; v.ps = ps;
        v.tgt = tgt; v.instr = instr; v.pcf = pcf; v.instr_d = instr_d; v.pcd = pcd;
        v.pc4d = pc4d; v.vd = vd; v.live = live; v.pce = pce; v.ve = ve;
        v.sc = sc; v.rc = rc; v.bc = bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, sf, sd, fd, fe, ps, input logic [31:0] tgt, instr);
        rst = r; StallF = sf; StallD = sd; FlushD = fd; FlushE = fe; PCSrcE = ps;
        PCTargetE = tgt; InstrF = instr;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " PCF"},       PCF,       v.pcf);
        check({tag, " InstrD"},    InstrD,    v.instr_d);
        check({tag, " PCD"},       PCD,       v.pcd);
        check({tag, " PCPlus4D"},  PCPlus4D,  v.pc4d);
        check({tag, " ValidD"},    32'(ValidD), 32'(v.vd));
        check({tag, " E ctl"},     32'({RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE}),
              v.live ? 32'(CTL_LIVE) : 32'd0);
        check({tag, " E idx"},     32'({Rs1E, Rs2E, RdE}), v.live ? 32'(IDX_LIVE) : 32'd0);
        check({tag, " PCE"},       PCE,       v.pce);
        check({tag, " ValidE"},    32'(ValidE), 32'(v.ve));
        check({tag, " StallCnt"},  StallCnt,  v.sc);
        check({tag, " RedirCnt"},  RedirCnt,  v.rc);
        check({tag, " BubbleCnt"}, BubbleCnt, v.bc);
    endtask

    initial begin
        //            rst sf sd fd fe ps tgt           instr  pcf           instr_d pcd           pc4d   vd live pce           ve sc rc bc
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h0,        NOP, 32'h0,        32'h0,  0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h4,        I1,  32'h0,        32'h4,  1, 1, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h8,        I1,  32'h4,        32'h8,  1, 1, 32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'hC,        I1,  32'h8,        32'hC,  1, 1, 32'h4,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h10,       I1,  32'hC,        32'h10, 1, 1, 32'h8,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 32'h0,        I2,  32'h0,        NOP, 32'h0,        32'h0,  0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h4,        I1,  32'h0,        32'h4,  1, 1, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I1,  32'h8,        I1,  32'h4,        32'h8,  1, 1, 32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,        BAD, 32'h8,        I1,  32'h4,        32'h8,  1, 0, 32'h0,        0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I2,  32'hC,        I2,  32'h8,        32'hC,  1, 1, 32'h4,        1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'h40,       BAD, 32'h40,       NOP, 32'h0,        32'h0,  0, 0, 32'h0,        0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I3,  32'h44,       I3,  32'h40,       32'h44, 1, 1, 32'h0,        0, 1, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 32'h80,       BAD, 32'h80,       NOP, 32'h0,        32'h0,  0, 1, 32'h40,       1, 2, 2, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, I1,  32'hFFFFFFFC, I1,  32'h80,       32'h84, 1, 1, 32'h0,        0, 2, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        I2,  32'h0,        I2,  32'hFFFFFFFC, 32'h0,  1, 1, 32'h80,       1, 2, 3, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        I3,  32'h4,        I2,  32'hFFFFFFFC, 32'h0,  1, 1, 32'hFFFFFFFC, 1, 3, 3, 2));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe, vecs[i].ps,
                  vecs[i].tgt, vecs[i].instr);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted while a load-use stall is in progress at PCF=0x24.
        drive(0, 0, 0, 0, 0, 1, 32'h24, I1);
        check("rs redirect PCF", PCF, 32'h24);
        drive(0, 1, 1, 0, 1, 0, 32'h0, I2);
        check("rs stall PCF", PCF, 32'h24);
        check("rs stall StallCnt", StallCnt, 32'd4);
        drive(1, 1, 1, 0, 1, 0, 32'h0, I2);
        check_all("rs reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0));

        // StallD held 20 cycles: the 4-bit counter saturates at 15, the 32-bit one keeps counting.
        for (int c = 1; c <= 20; c++) begin
            drive(0, 1, 1, 0, 0, 0, 32'h0, I1);
            if (c == 14) check("sat c14 StallCnt4", 32'(s_StallCnt), 32'd14);
            if (c == 15) check("sat c15 StallCnt4", 32'(s_StallCnt), 32'd15);
        end
        check("sat c20 StallCnt4", 32'(s_StallCnt), 32'd15);
        check("sat c20 StallCnt32", StallCnt, 32'd20);
        check("sat c20 RedirCnt4", 32'(s_RedirCnt), 32'd0);
        check("sat c20 PCF held", PCF, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
